mem_bus_arb: RTL and testbench
==============================

Name: mem_bus_arb

Overview:
- Two-requester arbiter that shares the single-port program/data RAM of the 8-bit computer.
- Requester 0 (LD) is the SPI ROM-loader bus port. Requester 1 (CPU) is the CPU fetch/load-store port.
- Issues at most one RAM access per cycle and routes read data back to the owner.
- Enforces a write-protected ROM region against CPU writes and provides a load-mode lockout for the CPU.

Parameters:
- ADDR_WIDTH, 8, RAM address width.
- DATA_WIDTH, 8, RAM data width.
- RD_LATENCY, 1, RAM read latency in cycles; legal values 1..3.
- MAX_BURST, 4, consecutive grants the current owner may keep while the other requester waits; legal values 1..15.
- ROM_TOP, 8'h7F, highest write-protected address for CPU writes.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous active-low reset.
- load_mode  in  1  high = ROM load in progress; CPU requests are not served.
- ld_req  in  1  LD access request.
- ld_we  in  1  LD write (1) / read (0).
- ld_addr  in  ADDR_WIDTH  LD address.
- ld_wdata  in  DATA_WIDTH  LD write data.
- ld_gnt  out  1  LD access accepted this cycle.
- ld_rvalid  out  1  LD read data valid.
- ld_rdata  out  DATA_WIDTH  LD read data.
- cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_gnt, cpu_rvalid, cpu_rdata: same as the LD set, for the CPU.
- cpu_wp_err  out  1  one-cycle pulse: a CPU write to the protected region was dropped.
- mem_en  out  1  RAM access enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_WIDTH  RAM address.
- mem_wdata  out  DATA_WIDTH  RAM write data.
- mem_rdata  in  DATA_WIDTH  RAM read data, valid RD_LATENCY cycles after the access.

Behaviour:
- Reset (sys_rst_n low, asynchronous):
  - All outputs 0.
  - last_owner = LD, burst_cnt = 0, read-return pipeline cleared.
  - No rvalid is ever emitted for accesses issued before reset.
- Effective CPU request: cpu_req_eff = cpu_req & ~load_mode.
- Grant (combinational, same cycle as request):
  - Exactly one requesting: that requester is granted.
  - Both requesting: last_owner is granted if burst_cnt < MAX_BURST; otherwise the other requester is granted.
  - Neither requesting: no grant, mem_en = 0.
- ld_gnt and cpu_gnt are one-hot or zero. A requester holds req, we, addr and wdata stable until it sees gnt. An access completes in the cycle gnt = 1.
- Mux: mem_en = any grant. mem_we, mem_addr and mem_wdata are taken from the granted requester; they are 0 when there is no grant.
- Owner/burst update at the clock edge:
  - Grant to last_owner: burst_cnt = min(burst_cnt + 1, 15).
  - Grant to the other requester: last_owner = it, burst_cnt = 1.
  - No grant: burst_cnt = 0, last_owner unchanged.
- Write protect:
  - Applies to a granted CPU write with cpu_addr <= ROM_TOP.
  - cpu_gnt = 1, but mem_en = 0 and mem_we = 0.
  - cpu_wp_err pulses high in the next cycle.
  - LD writes are never protected.
- Read return:
  - RD_LATENCY-deep shift register of {valid, owner}, loaded on every granted read (mem_en & ~mem_we).
  - At the pipeline output: owner LD gives ld_rvalid = 1; owner CPU gives cpu_rvalid = 1.
  - x_rdata = mem_rdata, gated to 0 when x_rvalid = 0.
  - Read issued in cycle t gives rvalid in cycle t + RD_LATENCY.
  - Back-to-back reads give back-to-back rvalids, in issue order.
- load_mode:
  - Assertion blocks new CPU grants immediately.
  - In-flight CPU reads still return their rvalid.
  - Deassertion: CPU is eligible in the same cycle.
- Simultaneous events:
  - load_mode rising in the same cycle as cpu_req: no cpu_gnt.
  - LD and CPU both idle for one cycle resets fairness (burst_cnt = 0).
- burst_cnt width: 4 bits, saturating.

Test Plan:
- Reset with both requests high: all outputs 0. After sys_rst_n deasserts, ld_req only, read addr 8'h10, RAM holds 8'hA5 → ld_gnt in cycle 0, mem_addr = 8'h10, ld_rvalid with ld_rdata = 8'hA5 in cycle RD_LATENCY, cpu_rvalid = 0.
- ld_req and cpu_req held high for 12 cycles, MAX_BURST = 4, last_owner = LD → grant pattern LD×4, CPU×4, LD×4; never both gnt.
- CPU write addr 8'h20 (≤ ROM_TOP 8'h7F), data 8'h55 → cpu_gnt = 1, mem_en = 0, cpu_wp_err one cycle later, RAM unchanged. Write to addr 8'h80 → mem_we = 1, mem_addr = 8'h80, mem_wdata = 8'h55, no error.
- load_mode = 1 with cpu_req held → no cpu_gnt for 20 cycles while the LD stream of writes 8'h00..8'h13 gets all grants. load_mode = 0 → cpu_gnt in the same cycle.
- Alternating LD/CPU reads every cycle, RD_LATENCY = 2 → rvalids alternate LD/CPU starting 2 cycles after the first grant, each with correct data.
- CPU read issued, sys_rst_n pulsed low before RD_LATENCY elapses → no cpu_rvalid after reset; first post-reset access behaves as in scenario 1.

Source files
------------

// File: rtl/mem_bus_arb.sv
// Two-requester arbiter sharing the single-port program/data RAM.
// Requester LD is the SPI ROM loader and requester CPU is the CPU port.
// Grants are combinational. The CPU is locked out while load_mode is high,
// and CPU writes into the ROM region are dropped and flagged.
module mem_bus_arb #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned MAX_BURST  = 4,
  parameter logic [ADDR_WIDTH-1:0] ROM_TOP = ADDR_WIDTH'(8'h7F)
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  load_mode,
  input  logic                  ld_req,
  input  logic                  ld_we,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_wdata,
  output logic                  ld_gnt,
  output logic                  ld_rvalid,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_gnt,
  output logic                  cpu_rvalid,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_wp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] MAX_BURST_C = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_SAT     = '1;

  typedef enum logic {
    OWN_LD  = 1'b0,
    OWN_CPU = 1'b1
  } owner_e;

  owner_e           last_owner, last_owner_nxt;
  logic [CNT_W-1:0] burst_cnt, burst_cnt_nxt;
  logic             cpu_req_eff;
  logic             wp_hit_c;
  logic [RD_LATENCY-1:0] ld_v_q, cpu_v_q;

  assign cpu_req_eff = cpu_req & ~load_mode;

  // Owner / burst state register
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_owner <= OWN_LD;
      burst_cnt  <= '0;
    end else begin
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

  // Next owner: extend the burst, hand over, or reset fairness when idle
  always_comb begin
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    if (ld_gnt || cpu_gnt) begin
      if ((ld_gnt ? OWN_LD : OWN_CPU) == last_owner) begin
        burst_cnt_nxt = (burst_cnt == CNT_SAT) ? burst_cnt : burst_cnt + CNT_W'(1);
      end else begin
        last_owner_nxt = ld_gnt ? OWN_LD : OWN_CPU;
        burst_cnt_nxt  = CNT_W'(1);
      end
    end else begin
      burst_cnt_nxt = '0;
    end
  end

  // Grant decision and RAM port mux; nothing is granted while in reset
  always_comb begin
    ld_gnt    = 1'b0;
    cpu_gnt   = 1'b0;
    wp_hit_c  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (sys_rst_n) begin
      if (ld_req && cpu_req_eff) begin
        // Owner keeps the bus until its burst allowance is used up
        if ((last_owner == OWN_LD) == (burst_cnt < MAX_BURST_C)) ld_gnt = 1'b1;
        else                                                     cpu_gnt = 1'b1;
      end else if (ld_req) begin
        ld_gnt = 1'b1;
      end else if (cpu_req_eff) begin
        cpu_gnt = 1'b1;
      end
    end
    if (ld_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end else if (cpu_gnt) begin
      wp_hit_c  = cpu_we && (cpu_addr <= ROM_TOP);
      mem_en    = ~wp_hit_c;
      mem_we    = cpu_we & ~wp_hit_c;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Read-return tracking per owner and the write-protect error pulse
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ld_v_q     <= '0;
      cpu_v_q    <= '0;
      cpu_wp_err <= 1'b0;
    end else begin
      ld_v_q[0]  <= ld_gnt & ~ld_we;
      cpu_v_q[0] <= cpu_gnt & ~cpu_we;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        ld_v_q[i]  <= ld_v_q[i-1];
        cpu_v_q[i] <= cpu_v_q[i-1];
      end
      cpu_wp_err <= wp_hit_c;
    end
  end

  assign ld_rvalid  = ld_v_q[RD_LATENCY-1];
  assign cpu_rvalid = cpu_v_q[RD_LATENCY-1];
  assign ld_rdata   = ld_rvalid  ? mem_rdata : '0;
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arb.sv
// Bench for mem_bus_arb: vector table of per-cycle requests and expected
// grants, a RAM model with 2-cycle read latency, and read-data scoreboards.
module tb_mem_bus_arb;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       load_mode = 1'b0;
  logic       ld_req = 1'b0, ld_we = 1'b0;
  logic [7:0] ld_addr = '0, ld_wdata = '0;
  logic       cpu_req = 1'b0, cpu_we = 1'b0;
  logic [7:0] cpu_addr = '0, cpu_wdata = '0;
  logic       ld_gnt, ld_rvalid, cpu_gnt, cpu_rvalid, cpu_wp_err;
  logic [7:0] ld_rdata, cpu_rdata;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata, mem_rdata;

  always #5 sys_clk = ~sys_clk;

  mem_bus_arb #(
    .ADDR_WIDTH(8), .DATA_WIDTH(8), .RD_LATENCY(2), .MAX_BURST(4), .ROM_TOP(8'h7F)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .load_mode(load_mode),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_wp_err(cpu_wp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // RAM model: initial contents addr ^ 8'hB5, read data two cycles later
  logic [7:0] ram [256];
  logic [7:0] rq0, rq1;
  logic       ram_init = 1'b1;
  always @(posedge sys_clk) begin
    if (ram_init) begin
      for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'hB5;
    end else if (mem_en && mem_we) begin
      ram[mem_addr] <= mem_wdata;
    end
    rq0 <= ram[mem_addr];
    rq1 <= rq0;
  end
  assign mem_rdata = rq1;

  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Read-data scoreboards, filled when a read is driven
  logic [7:0] ld_q[$];
  logic [7:0] cpu_q[$];

  always @(negedge sys_clk) begin
    logic [7:0] e;
    if (ld_rvalid) begin
      if (ld_q.size() == 0) check("ld_rvalid unexpected", 1, 0);
      else begin
        e = ld_q.pop_front();
        check("ld_rdata", 32'(ld_rdata), 32'(e));
      end
    end else check("ld_rdata gated", 32'(ld_rdata), 0);
    if (cpu_rvalid) begin
      if (cpu_q.size() == 0) check("cpu_rvalid unexpected", 1, 0);
      else begin
        e = cpu_q.pop_front();
        check("cpu_rdata", 32'(cpu_rdata), 32'(e));
      end
    end else check("cpu_rdata gated", 32'(cpu_rdata), 0);
  end

  // One cycle of stimulus; g = expected grant (0 none, 1 LD, 2 CPU)
  typedef struct {
    logic       lm;
    logic       lr, lw;
    logic [7:0] la, ld;
    logic       cr, cw;
    logic [7:0] ca, cd;
    int         g;
  } vec_t;

  function automatic vec_t mk(input logic lm, input logic lr, input logic lw,
                              input logic [7:0] la, input logic [7:0] ld,
                              input logic cr, input logic cw,
                              input logic [7:0] ca, input logic [7:0] cd, input int g);
    vec_t v;
    v.lm = lm; v.lr = lr; v.lw = lw; v.la = la; v.ld = ld;
    v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd; v.g = g;
    return v;
  endfunction

  // Expected-state model: RAM contents, read issue history, pending wp error
  logic [7:0] shadow [256];
  logic hl0, hl1, hc0, hc1, prev_wp;

  task automatic clear_model();
    hl0 = 0; hl1 = 0; hc0 = 0; hc1 = 0; prev_wp = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic e_lg, e_cg, prot, e_en, e_we, e_lv, e_cv;
    logic [7:0] e_addr, e_wd;
    load_mode = v.lm;
    ld_req = v.lr;  ld_we = v.lw;  ld_addr = v.la;  ld_wdata = v.ld;
    cpu_req = v.cr; cpu_we = v.cw; cpu_addr = v.ca; cpu_wdata = v.cd;
    e_lg   = (v.g == 1);
    e_cg   = (v.g == 2);
    prot   = e_cg && v.cw && (v.ca <= 8'h7F);
    e_en   = (e_lg || e_cg) && !prot;
    e_we   = e_lg ? v.lw : (e_cg ? (v.cw && !prot) : 1'b0);
    e_addr = e_lg ? v.la : (e_cg ? v.ca : 8'h00);
    e_wd   = e_lg ? v.ld : (e_cg ? v.cd : 8'h00);
    e_lv   = hl1;
    e_cv   = hc1;
    if (e_lg && !v.lw) ld_q.push_back(shadow[v.la]);
    if (e_cg && !v.cw) cpu_q.push_back(shadow[v.ca]);
    if (e_en && e_we) shadow[e_addr] = e_wd;
    @(negedge sys_clk);
    check($sformatf("v%0d ld_gnt", idx), 32'(ld_gnt), 32'(e_lg));
    check($sformatf("v%0d cpu_gnt", idx), 32'(cpu_gnt), 32'(e_cg));
    check($sformatf("v%0d mem_en", idx), 32'(mem_en), 32'(e_en));
    check($sformatf("v%0d mem_we", idx), 32'(mem_we), 32'(e_we));
    check($sformatf("v%0d mem_addr", idx), 32'(mem_addr), 32'(e_addr));
    check($sformatf("v%0d mem_wdata", idx), 32'(mem_wdata), 32'(e_wd));
    check($sformatf("v%0d cpu_wp_err", idx), 32'(cpu_wp_err), 32'(prev_wp));
    check($sformatf("v%0d ld_rvalid", idx), 32'(ld_rvalid), 32'(e_lv));
    check($sformatf("v%0d cpu_rvalid", idx), 32'(cpu_rvalid), 32'(e_cv));
    hl1 = hl0; hl0 = e_lg && !v.lw;
    hc1 = hc0; hc0 = e_cg && !v.cw;
    prev_wp = prot;
    @(posedge sys_clk); #1;
  endtask

  // Reset with both requesters active; every output must read 0
  task automatic do_reset();
    sys_rst_n = 1'b0;
    ld_req = 1'b1; cpu_req = 1'b1; ld_we = 1'b1; cpu_we = 1'b1;
    ld_addr = 8'h90; cpu_addr = 8'hC0; ld_wdata = 8'h11; cpu_wdata = 8'h22;
    @(negedge sys_clk);
    check("rst ld_gnt", 32'(ld_gnt), 0);
    check("rst cpu_gnt", 32'(cpu_gnt), 0);
    check("rst mem_en", 32'(mem_en), 0);
    check("rst mem_we", 32'(mem_we), 0);
    check("rst mem_addr", 32'(mem_addr), 0);
    check("rst mem_wdata", 32'(mem_wdata), 0);
    check("rst ld_rvalid", 32'(ld_rvalid), 0);
    check("rst cpu_rvalid", 32'(cpu_rvalid), 0);
    check("rst cpu_wp_err", 32'(cpu_wp_err), 0);
    @(posedge sys_clk); #1;
    ram_init = 1'b0;
    sys_rst_n = 1'b1;
    clear_model();
  endtask

  vec_t vq[$];
  vec_t vq2[$];
  vec_t idle;

  initial begin
    for (int i = 0; i < 256; i++) shadow[i] = 8'(i) ^ 8'hB5;
    clear_model();
    idle = mk(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0);

    // Single LD read after reset
    vq.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq.push_back(idle); vq.push_back(idle);
    // Both requesting for 12 cycles: LD x4, CPU x4, LD x4
    for (int k = 0; k < 12; k++)
      vq.push_back(mk(0, 1, 0, 8'h40, 8'h00, 1, 0, 8'h90, 8'h00, (k < 4 || k >= 8) ? 1 : 2));
    // CPU write into ROM region is dropped, above it goes through
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'h55, 2));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 1, 8'h80, 8'h55, 2));
    vq.push_back(idle);
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h20, 8'h00, 2));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h80, 8'h00, 2));
    vq.push_back(idle); vq.push_back(idle);
    // CPU read in flight, then load_mode rises with cpu_req still high
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h88, 8'h00, 2));
    for (int i = 0; i < 20; i++)
      vq.push_back(mk(1, 1, 1, 8'(i), 8'(i) ^ 8'h3C, 1, 0, 8'h90, 8'h00, 1));
    // load_mode drops: CPU wins at once (LD burst exhausted)
    vq.push_back(mk(0, 1, 0, 8'h05, 8'h00, 1, 0, 8'h90, 8'h00, 2));
    vq.push_back(mk(0, 1, 0, 8'h05, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq.push_back(idle); vq.push_back(idle);
    // Alternating single-requester reads
    vq.push_back(mk(0, 1, 0, 8'h01, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h81, 8'h00, 2));
    vq.push_back(mk(0, 1, 0, 8'h12, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hFE, 8'h00, 2));
    vq.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 8'h7F, 8'h00, 2));
    vq.push_back(idle); vq.push_back(idle);

    vq2.push_back(mk(0, 1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1));
    vq2.push_back(idle); vq2.push_back(idle); vq2.push_back(idle);

    do_reset();
    foreach (vq[i]) run_vec(vq[i], i);

    // CPU read, then reset before its data returns: no rvalid afterwards
    load_mode = 0; ld_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h90; cpu_wdata = 8'h00;
    @(negedge sys_clk);
    check("flight cpu_gnt", 32'(cpu_gnt), 1);
    @(posedge sys_clk); #1;
    do_reset();
    run_vec(idle, 100);
    run_vec(idle, 101);
    foreach (vq2[i]) run_vec(vq2[i], 200 + i);

    check("ld_q drained", 32'(ld_q.size()), 0);
    check("cpu_q drained", 32'(cpu_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
